// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parameterised UART receiver: parity modes,
// FSM state encoding and the expected-parity helper.
package uart_rx_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } rx_state_t;

   // Parity bit a transmitter would append to 'data' in the given mode.
   // Unused upper data bits are zero, so they do not disturb the XOR.
   function automatic logic exp_parity(input logic [7:0] data, input int mode);
      logic x;
      x = ^data;
      return (mode == PAR_ODD) ? ~x : x;
   endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchroniser for an asynchronous serial line followed by a
// 3-sample majority vote over the synchronised stream.
module uart_rx_sync_vote (
   input  logic uart_clk,
   input  logic rst_n,
   input  logic i_rxd,
   output logic o_rxd_s,
   output logic o_vote
);

   logic       r_meta;
   logic       r_sync;
   logic [1:0] r_hist;
   logic [2:0] w_taps;

   // Synchronise the line and keep the two previous synchronised samples;
   // everything resets to the idle (high) level.
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_hist <= 2'b11;
      end else begin
         r_meta <= i_rxd;
         r_sync <= r_meta;
         r_hist <= {r_hist[0], r_sync};
      end
   end

   // Window = current sample plus the two before it.
   assign w_taps  = {r_hist, r_sync};
   assign o_rxd_s = r_sync;
   assign o_vote  = (w_taps[0] & w_taps[1]) | (w_taps[0] & w_taps[2]) |
                    (w_taps[1] & w_taps[2]);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: DATA_BITS data bits LSB first, optional
// even/odd parity, 1 or 2 stop bits, OVS-times oversampling with a
// majority vote near mid-bit. Writes each completed frame to the RX FIFO
// and flags parity, framing and break conditions.
module uart_rx_param
   import uart_rx_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int OVS       = 16
) (
   input  logic       uart_clk,
   input  logic       rst_n,
   input  logic       uart_rxd,
   output logic [7:0] rf_data,
   output logic       fr_wrreq,
   output logic       parity_err,
   output logic       frame_err,
   output logic       break_det
);

   localparam int            TW        = $clog2(OVS);
   localparam logic [TW-1:0] TICK_VOTE = TW'(OVS / 2 + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
   localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
   localparam bit            HAS_PAR   = (PARITY != PAR_NONE);

   rx_state_t     r_state;
   rx_state_t     w_state_nxt;
   logic [TW-1:0] r_tick;
   logic [2:0]    r_idx;
   logic [7:0]    r_shreg;
   logic          r_pbit;
   logic          r_perr;
   logic          r_ferr;

   logic w_rxd_s;
   logic w_vote;
   logic w_at_vote;
   logic w_at_last;
   logic w_tick_clr;
   logic w_idx_clr;
   logic w_idx_inc;
   logic w_shift;
   logic w_par_smp;
   logic w_stop_smp;
   logic w_done;
   logic w_ferr_all;
   logic w_break;

   uart_rx_sync_vote u_sync (
      .uart_clk (uart_clk),
      .rst_n    (rst_n),
      .i_rxd    (uart_rxd),
      .o_rxd_s  (w_rxd_s),
      .o_vote   (w_vote)
   );

   assign w_at_vote  = (r_tick == TICK_VOTE);
   assign w_at_last  = (r_tick == TICK_LAST);
   // Framing error including the stop vote being taken this cycle.
   assign w_ferr_all = r_ferr | ~w_vote;
   assign w_break    = (r_shreg == 8'h00) && !r_pbit && w_ferr_all;

   // FSM state register.
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and datapath control decode.
   always_comb begin
      w_state_nxt = r_state;
      w_tick_clr  = 1'b0;
      w_idx_clr   = 1'b0;
      w_idx_inc   = 1'b0;
      w_shift     = 1'b0;
      w_par_smp   = 1'b0;
      w_stop_smp  = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_rxd_s) begin
               w_state_nxt = S_START;
               w_tick_clr  = 1'b1;
            end
         end
         S_START: begin
            if (w_at_vote && w_vote) begin
               w_state_nxt = S_IDLE;
            end else if (w_at_last) begin
               w_state_nxt = S_DATA;
               w_idx_clr   = 1'b1;
            end
         end
         S_DATA: begin
            w_shift = w_at_vote;
            if (w_at_last) begin
               if (r_idx == DATA_LAST) begin
                  w_idx_clr   = 1'b1;
                  w_state_nxt = HAS_PAR ? S_PARITY : S_STOP;
               end else begin
                  w_idx_inc = 1'b1;
               end
            end
         end
         S_PARITY: begin
            w_par_smp = w_at_vote;
            if (w_at_last) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            w_stop_smp = w_at_vote;
            // Finish at the last stop vote so an immediate start edge is seen.
            if (w_at_vote && (r_idx == STOP_LAST)) begin
               w_done      = 1'b1;
               w_state_nxt = w_break ? S_WAIT_HIGH : S_IDLE;
            end else if (w_at_last) begin
               w_idx_inc = 1'b1;
            end
         end
         S_WAIT_HIGH: begin
            if (w_rxd_s) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bit timing, data capture, error accumulation and FIFO-side outputs.
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick     <= '0;
         r_idx      <= '0;
         r_shreg    <= '0;
         r_pbit     <= 1'b0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         rf_data    <= '0;
         fr_wrreq   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
      end else begin
         fr_wrreq  <= 1'b0;
         break_det <= 1'b0;
         if (w_tick_clr || w_at_last) r_tick <= '0;
         else                         r_tick <= r_tick + TW'(1);
         if (w_tick_clr) begin
            r_shreg <= '0;
            r_pbit  <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
         end
         if (w_idx_clr)      r_idx <= '0;
         else if (w_idx_inc) r_idx <= r_idx + 3'd1;
         if (w_shift) r_shreg[r_idx] <= w_vote;
         if (w_par_smp) begin
            r_pbit <= w_vote;
            r_perr <= (w_vote != exp_parity(r_shreg, PARITY));
         end
         if (w_stop_smp && !w_vote) r_ferr <= 1'b1;
         if (w_done) begin
            if (w_break) begin
               break_det <= 1'b1;
            end else begin
               fr_wrreq   <= 1'b1;
               rf_data    <= r_shreg;
               parity_err <= r_perr;
               frame_err  <= w_ferr_all;
            end
         end
      end
   end

endmodule
